// File: rtl/fft_agu.sv
// fft_agu: address generator and sequencer for an in-place radix-2 DIT FFT.
// Walks stage s and butterfly j. For each butterfly it issues the read pair
// and the twiddle index. The write-back pair follows PIPE_DEPTH cycles later,
// and the pipeline is drained between stages.
module fft_agu #(
    parameter int unsigned LOG2_N     = 4,
    parameter int unsigned PIPE_DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       start_i,
    input  logic                       en_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [$clog2(LOG2_N)-1:0]  stage_o,
    output logic                       rd_valid_o,
    output logic [LOG2_N-1:0]          rd_addr_a_o,
    output logic [LOG2_N-1:0]          rd_addr_b_o,
    output logic [LOG2_N-2:0]          twid_idx_o,
    output logic                       wr_valid_o,
    output logic [LOG2_N-1:0]          wr_addr_a_o,
    output logic [LOG2_N-1:0]          wr_addr_b_o
);

    localparam int unsigned SW = $clog2(LOG2_N);
    localparam int unsigned AW = LOG2_N;
    localparam int unsigned JW = LOG2_N - 1;
    localparam int unsigned DW = (PIPE_DEPTH < 2) ? 1 : $clog2(PIPE_DEPTH + 1);

    localparam logic [JW-1:0] J_LAST = {JW{1'b1}};
    localparam logic [SW-1:0] S_LAST = SW'(LOG2_N - 1);
    localparam logic [DW-1:0] D_INIT = DW'(PIPE_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [SW-1:0]   stage_q, stage_d;
    logic [JW-1:0]   j_q, j_d;
    logic [DW-1:0]   drain_q, drain_d;

    logic            in_issue;
    logic [AW-1:0]   j_ext, bit_s, low_mask, addr_a, addr_b;
    logic [JW-1:0]   k_val;
    logic [SW-1:0]   tw_shift;

    logic            pipe_v_q [PIPE_DEPTH];
    logic [AW-1:0]   pipe_a_q [PIPE_DEPTH];
    logic [AW-1:0]   pipe_b_q [PIPE_DEPTH];

    // Sequencer state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            stage_q <= '0;
            j_q     <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            j_q     <= j_d;
            drain_q <= drain_d;
        end
    end

    // Next-state logic: issue N/2 butterflies, drain, advance stage or finish
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        j_d     = j_q;
        drain_d = drain_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_ISSUE;
                    stage_d = '0;
                    j_d     = '0;
                end
            end
            S_ISSUE: begin
                if (en_i) begin
                    j_d = j_q + JW'(1);
                    if (j_q == J_LAST) begin
                        state_d = S_DRAIN;
                        drain_d = D_INIT;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q == DW'(1)) begin
                    if (stage_q == S_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                        stage_d = stage_q + SW'(1);
                        j_d     = '0;
                    end
                end else begin
                    drain_d = drain_q - DW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Read address mapping: insert a zero at bit s of j; the partner sets bit s
    always_comb begin
        j_ext       = AW'(j_q);
        bit_s       = AW'(1) << stage_q;
        low_mask    = bit_s - AW'(1);
        addr_a      = ((j_ext & ~low_mask) << 1) | (j_ext & low_mask);
        addr_b      = addr_a | bit_s;
        k_val       = j_q & low_mask[JW-1:0];
        tw_shift    = S_LAST - stage_q;
        in_issue    = (state_q == S_ISSUE);
        rd_valid_o  = in_issue & en_i;
        rd_addr_a_o = in_issue ? addr_a : '0;
        rd_addr_b_o = in_issue ? addr_b : '0;
        twid_idx_o  = in_issue ? (k_val << tw_shift) : '0;
    end

    // Write-back delay line; shifts every cycle regardless of en_i
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                pipe_v_q[i] <= 1'b0;
                pipe_a_q[i] <= '0;
                pipe_b_q[i] <= '0;
            end
        end else begin
            pipe_v_q[0] <= rd_valid_o;
            pipe_a_q[0] <= rd_addr_a_o;
            pipe_b_q[0] <= rd_addr_b_o;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                pipe_v_q[i] <= pipe_v_q[i-1];
                pipe_a_q[i] <= pipe_a_q[i-1];
                pipe_b_q[i] <= pipe_b_q[i-1];
            end
        end
    end

    // Status and write-back outputs decoded from registers
    assign busy_o      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign done_o      = (state_q == S_DONE);
    assign stage_o     = stage_q;
    assign wr_valid_o  = pipe_v_q[PIPE_DEPTH-1];
    assign wr_addr_a_o = pipe_a_q[PIPE_DEPTH-1];
    assign wr_addr_b_o = pipe_b_q[PIPE_DEPTH-1];

endmodule

// File: tb/tb_fft_agu.sv
// Bench for fft_agu: scoreboarded N=16/D=2 unit plus a directed N=4/D=1 unit.
module tb_fft_agu;

    logic clk = 1'b0;
    logic rst_n, start_a, start_b, en;

    logic       busy_a, done_a, rv_a, wv_a;
    logic [1:0] stage_a;
    logic [3:0] ra_a, rb_a, wa_a, wb_a;
    logic [2:0] tw_a;

    logic       busy_b, done_b, rv_b, wv_b;
    logic [0:0] stage_b, tw_b;
    logic [1:0] ra_b, rb_b, wa_b, wb_b;

    always #5 clk = ~clk;

    fft_agu #(.LOG2_N(4), .PIPE_DEPTH(2)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .en_i(en),
        .busy_o(busy_a), .done_o(done_a), .stage_o(stage_a),
        .rd_valid_o(rv_a), .rd_addr_a_o(ra_a), .rd_addr_b_o(rb_a), .twid_idx_o(tw_a),
        .wr_valid_o(wv_a), .wr_addr_a_o(wa_a), .wr_addr_b_o(wb_a)
    );

    fft_agu #(.LOG2_N(2), .PIPE_DEPTH(1)) dut_small (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .en_i(en),
        .busy_o(busy_b), .done_o(done_b), .stage_o(stage_b),
        .rd_valid_o(rv_b), .rd_addr_a_o(ra_b), .rd_addr_b_o(rb_b), .twid_idx_o(tw_b),
        .wr_valid_o(wv_b), .wr_addr_a_o(wa_b), .wr_addr_b_o(wb_b)
    );

    typedef struct { int a; int b; int tw; int st; } rd_t;
    typedef struct { int a; int b; int due; } wr_t;

    rd_t rd_q[$];
    wr_t wr_q[$];
    int  touch [4][16];
    int  tests = 0;
    int  failed = 0;
    int  cyc = 0;

    // Expected behaviour of the N=4, D=1 unit for cycles 1..8 after start
    int e_rv  [1:8] = '{1, 1, 0, 1, 1, 0, 0, 0};
    int e_ra  [1:8] = '{0, 2, 0, 0, 1, 0, 0, 0};
    int e_rb  [1:8] = '{1, 3, 0, 2, 3, 0, 0, 0};
    int e_tw  [1:8] = '{0, 0, 0, 0, 1, 0, 0, 0};
    int e_wv  [1:8] = '{0, 1, 1, 0, 1, 1, 0, 0};
    int e_wa  [1:8] = '{0, 0, 2, 0, 0, 1, 0, 0};
    int e_wb  [1:8] = '{0, 1, 3, 0, 2, 3, 0, 0};
    int e_dn  [1:8] = '{0, 0, 0, 0, 0, 0, 1, 0};
    int e_bz  [1:8] = '{1, 1, 1, 1, 1, 1, 0, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s @cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    // Reference butterfly order: block-major, then offset within block
    task automatic load_model();
        rd_q.delete();
        wr_q.delete();
        for (int s = 0; s < 4; s++)
            for (int a = 0; a < 16; a++) touch[s][a] = 0;
        for (int s = 0; s < 4; s++)
            for (int blk = 0; blk < 16; blk += (2 << s))
                for (int k = 0; k < (1 << s); k++)
                    rd_q.push_back('{blk + k, blk + k + (1 << s), k * (8 >> s), s});
    endtask

    task automatic monitor();
        rd_t e;
        wr_t w;
        if (rv_a === 1'b1) begin
            chk("rd_expected", rd_q.size() != 0, 1);
            if (rd_q.size() != 0) begin
                e = rd_q.pop_front();
                chk("rd_a", ra_a, e.a);
                chk("rd_b", rb_a, e.b);
                chk("twid", tw_a, e.tw);
                chk("stage", stage_a, e.st);
                wr_q.push_back('{e.a, e.b, cyc + 2});
                touch[stage_a][ra_a]++;
                touch[stage_a][rb_a]++;
            end
        end
        if (wr_q.size() != 0 && wr_q[0].due == cyc) begin
            w = wr_q.pop_front();
            chk("wr_valid", wv_a, 1);
            if (wv_a === 1'b1) begin
                chk("wr_a", wa_a, w.a);
                chk("wr_b", wb_a, w.b);
            end
        end else begin
            chk("wr_idle", wv_a, 0);
        end
    endtask

    task automatic step(input logic sa, input logic sb, input logic e, input logic r);
        @(posedge clk);
        #1;
        cyc++;
        start_a = sa;
        start_b = sb;
        en      = e;
        rst_n   = r;
        if (!r) begin
            rd_q.delete();
            wr_q.delete();
        end
        #1;
        monitor();
    endtask

    task automatic end_run();
        int bad;
        bad = 0;
        chk("rd_q_drained", rd_q.size(), 0);
        chk("wr_q_drained", wr_q.size(), 0);
        for (int s = 0; s < 4; s++)
            for (int a = 0; a < 16; a++)
                if (touch[s][a] != 1) bad++;
        chk("touch_once", bad, 0);
    endtask

    task automatic chk_reset_a();
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_stage", stage_a, 0);
        chk("rst_rv", rv_a, 0);
        chk("rst_ra", ra_a, 0);
        chk("rst_rb", rb_a, 0);
        chk("rst_tw", tw_a, 0);
        chk("rst_wv", wv_a, 0);
        chk("rst_wa", wa_a, 0);
        chk("rst_wb", wb_a, 0);
    endtask

    initial begin
        logic ev;
        rst_n   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        en      = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk_reset_a();
        chk("rst_b_busy", busy_b, 0);
        chk("rst_b_rv", rv_b, 0);
        chk("rst_b_wv", wv_b, 0);
        chk("rst_b_rb", rb_b, 0);

        step(0, 0, 1, 1);
        step(0, 0, 1, 1);

        // Full run, with start pulses in ISSUE, DRAIN and DONE that must be ignored
        load_model();
        cyc = -1;
        step(1, 0, 1, 1);
        for (int c = 1; c <= 43; c++) begin
            step(c == 5 || c == 9 || c == 41, 0, 1, 1);
            if (c == 1) begin
                chk("c1_rv", rv_a, 1);
                chk("c1_ra", ra_a, 0);
                chk("c1_rb", rb_a, 1);
                chk("c1_tw", tw_a, 0);
            end
            if (c == 3) begin
                chk("c3_wv", wv_a, 1);
                chk("c3_wa", wa_a, 0);
                chk("c3_wb", wb_a, 1);
            end
            if (c == 9 || c == 10) begin
                chk("drain_no_rd", rv_a, 0);
                chk("drain_busy", busy_a, 1);
            end
            if (c == 12) begin
                chk("map_s1j1_a", ra_a, 1);
                chk("map_s1j1_b", rb_a, 3);
                chk("map_s1j1_tw", tw_a, 4);
            end
            if (c == 27) begin
                chk("map_s2j6_a", ra_a, 10);
                chk("map_s2j6_b", rb_a, 14);
                chk("map_s2j6_tw", tw_a, 4);
            end
            if (c == 36) begin
                chk("map_s3j5_a", ra_a, 5);
                chk("map_s3j5_b", rb_a, 13);
                chk("map_s3j5_tw", tw_a, 5);
            end
            chk("run_done", done_a, c == 41);
            chk("run_busy", busy_a, c <= 40);
        end
        end_run();

        // Three-cycle stall in stage 0
        load_model();
        cyc = -1;
        step(1, 0, 1, 1);
        for (int c = 1; c <= 46; c++) begin
            ev = !(c >= 4 && c <= 6);
            step(0, 0, ev, 1);
            if (!ev) begin
                chk("stall_rv", rv_a, 0);
                chk("stall_hold_a", ra_a, rd_q[0].a);
                chk("stall_hold_b", rb_a, rd_q[0].b);
                chk("stall_hold_tw", tw_a, rd_q[0].tw);
            end
            if (c >= 5 && c <= 9) chk("stall_wr_gap", wv_a, !(c >= 6 && c <= 8));
            chk("stall_done", done_a, c == 44);
            chk("stall_busy", busy_a, c <= 43);
        end
        end_run();

        // Reset mid-transform, then restart
        load_model();
        cyc = -1;
        step(1, 0, 1, 1);
        for (int c = 1; c <= 60; c++) begin
            step(c == 18, 0, 1, !(c == 15 || c == 16));
            if (c == 15) chk_reset_a();
            if (c == 18) load_model();
            if (c == 19) begin
                chk("rst_restart_rv", rv_a, 1);
                chk("rst_restart_ra", ra_a, 0);
                chk("rst_restart_rb", rb_a, 1);
            end
            chk("rst_run_done", done_a, c == 59);
            chk("rst_run_busy", busy_a, (c <= 14) || (c >= 19 && c <= 58));
        end
        end_run();

        // N=4, PIPE_DEPTH=1 unit
        cyc = -1;
        step(0, 1, 1, 1);
        for (int c = 1; c <= 8; c++) begin
            step(0, 0, 1, 1);
            chk("small_rv", rv_b, e_rv[c]);
            chk("small_ra", ra_b, e_ra[c]);
            chk("small_rb", rb_b, e_rb[c]);
            chk("small_tw", tw_b, e_tw[c]);
            chk("small_wv", wv_b, e_wv[c]);
            if (e_wv[c] == 1) begin
                chk("small_wa", wa_b, e_wa[c]);
                chk("small_wb", wb_b, e_wb[c]);
            end
            chk("small_done", done_b, e_dn[c]);
            chk("small_busy", busy_b, e_bz[c]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
